// File: rtl/sync_pkg.sv
// Shared types and constants for the destination-domain bus synchroniser.
package sync_pkg;

  typedef enum logic {
    SYNC_LEVEL  = 1'b0,
    SYNC_FILTER = 1'b1
  } sync_mode_e;

  localparam int SYNC_MIN_STAGES = 2;

`ifdef SYNC_META_SIM
  // Setup/hold window around each CP edge, in the simulation time unit.
  localparam shortreal SYNC_TS_DEF = 0.2;
  localparam shortreal SYNC_TH_DEF = 0.1;
`endif

endpackage

// File: rtl/sync_chain.sv
// DW x STAGES flop chain clocked by CP; only the first stage sees the
// asynchronous D, and only that stage is disturbed by the optional meta model.
module sync_chain
  import sync_pkg::*;
#(
  parameter int              DW      = 8,
  parameter int              STAGES  = 2,
  parameter logic [DW-1:0]   RST_VAL = '0
) (
  input  logic          CP,
  input  logic          CLR,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] S
);

  logic [DW-1:0] s0;
  logic [DW-1:0] s_tail [1:STAGES-1];

`ifdef SYNC_META_SIM
  realtime t_d_chg = -1.0e9;
  realtime t_cp    = -1.0e9;

  // A D change just after an edge corrupts the value that edge captured.
  always @(D) begin
    t_d_chg = $realtime;
    if (CLR && (($realtime - t_cp) < SYNC_TH_DEF)) s0 = s0 ^ DW'($urandom);
  end

  always @(posedge CP or negedge CLR) begin
    if (!CLR) begin
      s0 <= RST_VAL;
    end else begin
      t_cp = $realtime;
      if (($realtime - t_d_chg) < SYNC_TS_DEF) s0 <= D ^ DW'($urandom);
      else                                    s0 <= D;
    end
  end
`else
  always_ff @(posedge CP or negedge CLR) begin
    if (!CLR) s0 <= RST_VAL;
    else      s0 <= D;
  end
`endif

  always_ff @(posedge CP or negedge CLR) begin
    if (!CLR) begin
      for (int k = 1; k < STAGES; k++) s_tail[k] <= RST_VAL;
    end else begin
      s_tail[1] <= s0;
      for (int k = 2; k < STAGES; k++) s_tail[k] <= s_tail[k-1];
    end
  end

  assign S = s_tail[STAGES-1];

endmodule

// File: rtl/sync_bus_filt.sv
// Receive-side CDC synchroniser: flop chain, optional stability filter,
// per-bit change pulses, update strobe and saturating event counter.
module sync_bus_filt
  import sync_pkg::*;
#(
  parameter int              DW      = 8,
  parameter int              STAGES  = 2,
  parameter int              MODE    = 0,
  parameter int              FILT    = 2,
  parameter logic [DW-1:0]   RST_VAL = '0,
  parameter int              CNTW    = 16
) (
  input  logic            CP,
  input  logic            CLR,
  input  logic [DW-1:0]   D,
  output logic [DW-1:0]   Q,
  output logic [DW-1:0]   P,
  output logic            VLD,
  output logic [CNTW-1:0] EVT_CNT
);

  if (STAGES < SYNC_MIN_STAGES) begin : g_chk_stages
    $fatal(1, "sync_bus_filt: STAGES=%0d below minimum %0d", STAGES, SYNC_MIN_STAGES);
  end
  if (FILT < 1) begin : g_chk_filt
    $fatal(1, "sync_bus_filt: FILT=%0d must be at least 1", FILT);
  end
  if ((MODE < 0) || (MODE > 1)) begin : g_chk_mode
    $fatal(1, "sync_bus_filt: MODE=%0d is not LEVEL(0) or FILTER(1)", MODE);
  end

  logic [DW-1:0] s_sync;
  logic [DW-1:0] q_next;
  logic [DW-1:0] q_diff;

  sync_chain #(
    .DW      (DW),
    .STAGES  (STAGES),
    .RST_VAL (RST_VAL)
  ) u_chain (
    .CP  (CP),
    .CLR (CLR),
    .D   (D),
    .S   (s_sync)
  );

  if (MODE == int'(SYNC_FILTER)) begin : g_filter
    localparam int            SW      = $clog2(FILT + 1);
    localparam logic [SW-1:0] FILT_TC = SW'(FILT);

    logic [DW-1:0] cand;
    logic [SW-1:0] stab;

    // stab counts edges on which S matched cand, parking at FILT.
    always_ff @(posedge CP or negedge CLR) begin
      if (!CLR) begin
        cand <= RST_VAL;
        stab <= '0;
      end else if (s_sync != cand) begin
        cand <= s_sync;
        stab <= '0;
      end else if (stab < FILT_TC) begin
        stab <= stab + 1'b1;
      end
    end

    assign q_next = (stab == FILT_TC) ? cand : Q;
  end else begin : g_level
    assign q_next = s_sync;
  end

  assign q_diff = q_next ^ Q;

  // P, VLD and the counter step on the same edge that publishes the new Q.
  always_ff @(posedge CP or negedge CLR) begin
    if (!CLR) begin
      Q       <= RST_VAL;
      P       <= '0;
      VLD     <= 1'b0;
      EVT_CNT <= '0;
    end else begin
      Q   <= q_next;
      P   <= q_diff;
      VLD <= |q_diff;
      if ((|q_diff) && !(&EVT_CNT)) EVT_CNT <= EVT_CNT + 1'b1;
    end
  end

endmodule
